// File: rtl/bus_tenure_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_tenure_arbiter_pkg
// Purpose  : Shared types and defaults for the snoop-bus tenure arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_tenure_arbiter_pkg;

    localparam int NUM_CPUS               = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        TENURE = 2'd1,
        TURN   = 2'd2
    } arb_state_t;

endpackage : bus_tenure_arbiter_pkg
`default_nettype wire

// File: rtl/bus_tenure_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational circular priority encoder; first set req at or
//            after ptr, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import bus_tenure_arbiter_pkg::*;
#(
    parameter int N_REQ = NUM_CPUS
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW:0] pos;

    // Walk from the farthest offset back to ptr so the closest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N_REQ)) begin
                pos = pos - (IW+1)'(N_REQ);
            end
            if (req[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/bus_tenure_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_tenure_arbiter
// Purpose  : Round-robin snoop-bus tenure arbiter with one-cycle turnaround.
//            Optional tenure watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_tenure_arbiter
    import bus_tenure_arbiter_pkg::*;
#(
    parameter int N_REQ          = NUM_CPUS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         busy,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     timeout,
    output logic [$clog2(N_REQ)-1:0] timeout_id
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("bus_tenure_arbiter: N_REQ and TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             tenure_end;
    logic [IW-1:0]    ptr_next;
    logic             do_release;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign tenure_end = ~req[gid_q] & ~busy[gid_q];
    assign ptr_next   = (gid_q == IW'(N_REQ - 1)) ? '0 : gid_q + IW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          cnt_hit;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] toid_q, toid_d;

    assign cnt_inc = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    assign cnt_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        do_release = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        toid_d     = toid_q;
`endif
        case (state_q)
            // TURN is the dead cycle; it also arbitrates so the next grant
            // lands immediately after it.
            ARB, TURN: begin
                state_d = ARB;
                if (pick_found) begin
                    state_d         = TENURE;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gid_d           = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            TENURE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (tenure_end) begin
                    do_release = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_hit) begin
                    do_release = 1'b1;
                    timeout_d  = 1'b1;
                    toid_d     = gid_q;
                end
`endif
            end
            default: state_d = ARB;
        endcase

        if (do_release) begin
            state_d = TURN;
            gnt_d   = '0;
            gid_d   = '0;
            ptr_d   = ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            gnt_q   <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            toid_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            toid_q    <= toid_d;
        end
    end

    assign timeout    = timeout_q;
    assign timeout_id = toid_q;
`else
    assign timeout    = 1'b0;
    assign timeout_id = '0;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gid_q;

endmodule : bus_tenure_arbiter
`default_nettype wire
